bscan_seq: RTL

Boundary-scan chain sequencer for the SDRAM/IO pad ring. It accepts one scan request at a time and drives the shared `BScanShift`, `BScanClock`, `BScanMode` and `BScanUpdate` nets plus the chain input `bscan_data[0]`. A request runs an optional capture, a full-length shift, and an optional update, and the block returns the bits shifted out of the chain's far end. It sits between the test/config register block and the `io1_sub` pad ring, replacing direct software toggling of scan pins.

---
 rtl/bscan_seq_pkg.sv | 27 ++
 rtl/bscan_clkgen.sv | 43 ++++
 rtl/bscan_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bscan_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bscan_seq_pkg
// Brief    : Shared state encoding and default sizing for the boundary-scan
//            chain sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package bscan_seq_pkg;

    localparam int BSCAN_CHAIN_LEN_DEFAULT = 43;
    localparam int BSCAN_CLK_DIV_DEFAULT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_RESP    = 3'd4
    } bscan_state_t;

    // States in which the chain control nets are being driven.
    function automatic logic is_active(input bscan_state_t st);
        return (st == ST_CAPTURE) || (st == ST_SHIFT) || (st == ST_UPDATE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bscan_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : bscan_clkgen
// Brief    : Scan-clock divider. Counts 2*CLK_DIV cycles per pulse while
//            enabled and parks at the start of the low phase otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module bscan_clkgen
    import bscan_seq_pkg::*;
#(
    parameter int CLK_DIV = BSCAN_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_l,
    input  logic en,
    output logic fall_stb,
    output logic rise_stb,
    output logic pulse_done
);

    localparam int CNT_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_rise_cnt = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(2 * CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_cnt <= '0;
        end else if (!en || (r_cnt == c_last_cnt)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Strobes mark the clk edge on which the scan clock changes level.
    assign rise_stb   = en && (r_cnt == c_rise_cnt);
    assign fall_stb   = en && (r_cnt == c_last_cnt);
    assign pulse_done = fall_stb;

endmodule
`default_nettype wire

// File: rtl/bscan_seq.sv
`default_nettype none
// ============================================================================
// Module   : bscan_seq
// Brief    : Boundary-scan chain sequencer: optional capture, full-length
//            shift, optional update, returns the bits shifted out.
// Config   : define BSCAN_SEQ_ABORT_EN to add the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module bscan_seq
    import bscan_seq_pkg::*;
#(
    parameter int CHAIN_LEN = BSCAN_CHAIN_LEN_DEFAULT,
    parameter int CLK_DIV   = BSCAN_CLK_DIV_DEFAULT
) (
`ifdef BSCAN_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_capture,
    input  logic                 req_update,
    input  logic [CHAIN_LEN-1:0] req_data,
    input  logic                 mode_en,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 bscan_si,
    input  logic                 bscan_so,
    output logic                 bscan_shift,
    output logic                 bscan_clock,
    output logic                 bscan_mode,
    output logic                 bscan_update
);

    localparam int PCNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [PCNT_W-1:0] c_last_pulse = PCNT_W'(CHAIN_LEN - 1);

    bscan_state_t         r_state;
    logic                 r_ready;
    logic                 r_valid;
    logic [CHAIN_LEN-1:0] r_rsp;
    logic [CHAIN_LEN-1:0] r_sreg;
    logic [PCNT_W-1:0]    r_pcnt;
    logic                 r_upd_req;
    logic                 r_si;
    logic                 r_shift;
    logic                 r_bclk;
    logic                 r_mode;
    logic                 r_update;

    logic                 w_abort;
    logic                 w_active;
    logic                 w_gen_en;
    logic                 w_fall_stb;
    logic                 w_rise_stb;
    logic                 w_pulse_done;
    logic [CHAIN_LEN-1:0] w_sreg_next;
    logic [CHAIN_LEN-1:0] w_rsp_next;

`ifdef BSCAN_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_active    = is_active(r_state);
    assign w_gen_en    = w_active && !w_abort;
    assign w_sreg_next = r_sreg >> 1;

    // Far-end bit enters at the top so pulse i lands in bit i after the last shift.
    generate
        if (CHAIN_LEN > 1) begin : g_rsp_multi
            assign w_rsp_next = {bscan_so, r_rsp[CHAIN_LEN-1:1]};
        end else begin : g_rsp_single
            assign w_rsp_next = bscan_so;
        end
    endgenerate

    bscan_clkgen #(
        .CLK_DIV    (CLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .reset_l    (reset_l),
        .en         (w_gen_en),
        .fall_stb   (w_fall_stb),
        .rise_stb   (w_rise_stb),
        .pulse_done (w_pulse_done)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_rsp     <= '0;
            r_sreg    <= '0;
            r_pcnt    <= '0;
            r_upd_req <= 1'b0;
            r_si      <= 1'b0;
            r_shift   <= 1'b0;
            r_bclk    <= 1'b0;
            r_mode    <= 1'b0;
            r_update  <= 1'b0;
        end else if (w_abort && w_active) begin
            r_state  <= ST_IDLE;
            r_ready  <= 1'b1;
            r_si     <= 1'b0;
            r_shift  <= 1'b0;
            r_bclk   <= 1'b0;
            r_update <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mode <= mode_en;
                    if (req_valid) begin
                        r_ready   <= 1'b0;
                        r_upd_req <= req_update;
                        r_sreg    <= req_data;
                        r_pcnt    <= '0;
                        if (req_capture) begin
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_state <= ST_SHIFT;
                            r_shift <= 1'b1;
                            r_si    <= req_data[0];
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (w_rise_stb) begin
                        r_bclk <= 1'b1;
                    end
                    if (w_pulse_done) begin
                        r_bclk  <= 1'b0;
                        r_state <= ST_SHIFT;
                        r_shift <= 1'b1;
                        r_si    <= r_sreg[0];
                    end
                end

                ST_SHIFT: begin
                    if (w_rise_stb) begin
                        r_bclk <= 1'b1;
                        r_rsp  <= w_rsp_next;
                    end
                    if (w_fall_stb) begin
                        r_bclk <= 1'b0;
                    end
                    if (w_pulse_done) begin
                        if (r_pcnt == c_last_pulse) begin
                            r_shift <= 1'b0;
                            r_si    <= 1'b0;
                            if (r_upd_req) begin
                                r_state  <= ST_UPDATE;
                                r_update <= 1'b1;
                            end else begin
                                r_state <= ST_RESP;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_pcnt <= r_pcnt + PCNT_W'(1);
                            r_sreg <= w_sreg_next;
                            r_si   <= w_sreg_next[0];
                        end
                    end
                end

                ST_UPDATE: begin
                    // Update net reuses the divider: high in the low phase, low in the high phase.
                    if (w_rise_stb) begin
                        r_update <= 1'b0;
                    end
                    if (w_pulse_done) begin
                        r_state <= ST_RESP;
                        r_valid <= 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready    = r_ready;
    assign rsp_valid    = r_valid;
    assign rsp_data     = r_rsp;
    assign bscan_si     = r_si;
    assign bscan_shift  = r_shift;
    assign bscan_clock  = r_bclk;
    assign bscan_mode   = r_mode;
    assign bscan_update = r_update;

endmodule
`default_nettype wire
